// File: rtl/udma_hyper_pkg.sv
// Shared types and helpers for the uDMA HyperBus burst splitter:
// FSM state encoding and the page-boundary configuration decode.
package udma_hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALC      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RECOVER   = 3'd4
  } state_e;

  localparam logic [2:0] PB_128B  = 3'd0;
  localparam logic [2:0] PB_256B  = 3'd1;
  localparam logic [2:0] PB_512B  = 3'd2;
  localparam logic [2:0] PB_1024B = 3'd3;
  // Encodings from here upwards disable the page boundary entirely.
  localparam logic [2:0] PB_NONE  = 3'd4;

  function automatic logic has_page_bound(input logic [2:0] pb);
    return pb < PB_NONE;
  endfunction

  // Page size in bytes; 0 when no boundary is configured.
  function automatic logic [31:0] page_bytes(input logic [2:0] pb);
    case (pb)
      PB_128B:  return 32'd128;
      PB_256B:  return 32'd256;
      PB_512B:  return 32'd512;
      PB_1024B: return 32'd1024;
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/udma_hyper_chunk_calc.sv
// Combinational sub-burst length: min(remaining, bytes to page end, CS-low limit),
// evaluated one bit wider than the byte-count field so "unlimited" never wins.
module udma_hyper_chunk_calc
  import udma_hyper_pkg::*;
#(
  parameter int TRANS_SIZE   = 16,
  parameter int HYPER_AWIDTH = 32
) (
  input  logic [TRANS_SIZE-1:0]   remaining,
  input  logic [HYPER_AWIDTH-1:0] addr,
  input  logic [2:0]              page_bound,
  input  logic [31:0]             t_cs_max,
  output logic [TRANS_SIZE-1:0]   chunk
);

  localparam int CW = TRANS_SIZE + 1;
  localparam logic [32:0] CS_CAP = 33'((64'd1 << TRANS_SIZE) - 64'd1);

  logic [HYPER_AWIDTH-1:0] page;
  logic [HYPER_AWIDTH-1:0] to_bound;
  logic [32:0]             cs_dbl;
  logic [CW-1:0]           rem_w;
  logic [CW-1:0]           bound_w;
  logic [CW-1:0]           cs_w;
  logic [CW-1:0]           min_rb;
  logic [CW-1:0]           min_all;

  always_comb begin
    page     = HYPER_AWIDTH'(page_bytes(page_bound));
    to_bound = page - (addr & (page - HYPER_AWIDTH'(1)));
    rem_w    = CW'(remaining);
    bound_w  = has_page_bound(page_bound) ? CW'(to_bound) : '1;

    // Two bytes move per CS-low clock (DDR), capped at the largest byte count.
    cs_dbl = {t_cs_max, 1'b0};
    if (t_cs_max == 32'd0) begin
      cs_w = '1;
    end else if (cs_dbl > CS_CAP) begin
      cs_w = CW'(CS_CAP);
    end else begin
      cs_w = CW'(cs_dbl);
    end

    min_rb  = (rem_w < bound_w) ? rem_w : bound_w;
    min_all = (min_rb < cs_w) ? min_rb : cs_w;
    chunk   = TRANS_SIZE'(min_all);
  end

endmodule

// File: rtl/udma_hyper_burst_splitter.sv
// Splits one HyperBus transfer request into page- and tCSM-bounded sub-bursts,
// one outstanding at a time, with a read/write-recovery gap between CS assertions.
module udma_hyper_burst_splitter
  import udma_hyper_pkg::*;
#(
  parameter int TRANS_SIZE   = 16,
  parameter int HYPER_AWIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              cfg_page_bound_i,
  input  logic [31:0]             cfg_t_cs_max_i,
  input  logic [31:0]             cfg_t_read_write_recovery_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [HYPER_AWIDTH-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]   req_size_i,
  input  logic                    req_rwn_i,
  output logic                    sub_valid_o,
  input  logic                    sub_ready_i,
  output logic [HYPER_AWIDTH-1:0] sub_addr_o,
  output logic [TRANS_SIZE-1:0]   sub_size_o,
  output logic                    sub_rwn_o,
  output logic                    sub_last_o,
  input  logic                    sub_done_i,
  output logic                    busy_o
);

  state_e                  state_reg;
  state_e                  state_next;

  logic [HYPER_AWIDTH-1:0] addr_reg;
  logic [TRANS_SIZE-1:0]   remaining_reg;
  logic                    rwn_reg;
  logic [2:0]              pb_reg;
  logic [31:0]             cs_max_reg;
  logic [31:0]             rec_reg;
  logic [31:0]             rec_cnt_reg;
  logic [HYPER_AWIDTH-1:0] sub_addr_reg;
  logic [TRANS_SIZE-1:0]   sub_size_reg;
  logic                    sub_last_reg;
  logic [TRANS_SIZE-1:0]   chunk;

  udma_hyper_chunk_calc #(
    .TRANS_SIZE   (TRANS_SIZE),
    .HYPER_AWIDTH (HYPER_AWIDTH)
  ) u_chunk_calc (
    .remaining  (remaining_reg),
    .addr       (addr_reg),
    .page_bound (pb_reg),
    .t_cs_max   (cs_max_reg),
    .chunk      (chunk)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready_o = 1'b0;
    sub_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        req_ready_o = ~rst_i;
        busy_o      = 1'b0;
        // Zero-length requests are consumed without leaving IDLE.
        if (req_valid_i && (req_size_i != '0)) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        sub_valid_o = 1'b1;
        if (sub_ready_i) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (sub_done_i) begin
          if (rec_reg != 32'd0) begin
            state_next = ST_RECOVER;
          end else begin
            state_next = sub_last_reg ? ST_IDLE : ST_CALC;
          end
        end
      end
      ST_RECOVER: begin
        if (rec_cnt_reg == 32'd0) begin
          state_next = sub_last_reg ? ST_IDLE : ST_CALC;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      rwn_reg       <= 1'b0;
      pb_reg        <= '0;
      cs_max_reg    <= '0;
      rec_reg       <= '0;
      rec_cnt_reg   <= '0;
      sub_addr_reg  <= '0;
      sub_size_reg  <= '0;
      sub_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Configuration is frozen here for the whole request.
          if (req_valid_i) begin
            addr_reg      <= req_addr_i;
            remaining_reg <= req_size_i;
            rwn_reg       <= req_rwn_i;
            pb_reg        <= cfg_page_bound_i;
            cs_max_reg    <= cfg_t_cs_max_i;
            rec_reg       <= cfg_t_read_write_recovery_i;
          end
        end
        ST_CALC: begin
          sub_addr_reg <= addr_reg;
          sub_size_reg <= chunk;
          sub_last_reg <= (chunk == remaining_reg);
        end
        ST_ISSUE: begin
          if (sub_ready_i) begin
            addr_reg      <= addr_reg + HYPER_AWIDTH'(sub_size_reg);
            remaining_reg <= remaining_reg - sub_size_reg;
          end
        end
        ST_WAIT_DONE: begin
          if (sub_done_i && (rec_reg != 32'd0)) begin
            rec_cnt_reg <= rec_reg - 32'd1;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt_reg != 32'd0) begin
            rec_cnt_reg <= rec_cnt_reg - 32'd1;
          end
        end
        default: begin
          rec_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign sub_addr_o = sub_addr_reg;
  assign sub_size_o = sub_size_reg;
  assign sub_rwn_o  = rwn_reg;
  assign sub_last_o = sub_last_reg;

endmodule

// File: tb/tb_udma_hyper_burst_splitter.sv
// Randomized bench for udma_hyper_burst_splitter against an arithmetic
// reference model of the sub-burst split and its handshake/recovery timing.
module tb_udma_hyper_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  cfg_page_bound_i = '0;
  logic [31:0] cfg_t_cs_max_i = '0;
  logic [31:0] cfg_t_read_write_recovery_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [15:0] req_size_i = '0;
  logic        req_rwn_i = 1'b0;
  logic        sub_valid_o;
  logic        sub_ready_i = 1'b0;
  logic [31:0] sub_addr_o;
  logic [15:0] sub_size_o;
  logic        sub_rwn_o;
  logic        sub_last_o;
  logic        sub_done_i = 1'b0;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned size;
    bit          last;
  } sub_t;

  sub_t exp_q[$];

  always #5 clk = ~clk;

  udma_hyper_burst_splitter #(
    .TRANS_SIZE   (16),
    .HYPER_AWIDTH (32)
  ) dut (
    .clk_i                       (clk),
    .rst_i                       (rst_i),
    .cfg_page_bound_i            (cfg_page_bound_i),
    .cfg_t_cs_max_i              (cfg_t_cs_max_i),
    .cfg_t_read_write_recovery_i (cfg_t_read_write_recovery_i),
    .req_valid_i                 (req_valid_i),
    .req_ready_o                 (req_ready_o),
    .req_addr_i                  (req_addr_i),
    .req_size_i                  (req_size_i),
    .req_rwn_i                   (req_rwn_i),
    .sub_valid_o                 (sub_valid_o),
    .sub_ready_i                 (sub_ready_i),
    .sub_addr_o                  (sub_addr_o),
    .sub_size_o                  (sub_size_o),
    .sub_rwn_o                   (sub_rwn_o),
    .sub_last_o                  (sub_last_o),
    .sub_done_i                  (sub_done_i),
    .busy_o                      (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference split: walk the request, each piece bounded by page end and 2*tCSM bytes.
  task automatic build_expected(input logic [31:0] addr, input int unsigned size,
                                input logic [2:0] pb, input logic [31:0] cs_max);
    longint      rem;
    longint      lim;
    longint      page;
    longint      cs;
    logic [31:0] a;
    sub_t        s;
    exp_q.delete();
    rem = size;
    a   = addr;
    while (rem > 0) begin
      lim = rem;
      if (pb < 3'd4) begin
        page = 128 << pb;
        if (page - (longint'(a) % page) < lim) lim = page - (longint'(a) % page);
      end
      if (cs_max != 32'd0) begin
        cs = 2 * longint'(cs_max);
        if (cs > 65535) cs = 65535;
        if (cs < lim) lim = cs;
      end
      s.addr = a;
      s.size = int'(lim);
      s.last = (lim == rem);
      exp_q.push_back(s);
      a   = a + 32'(lim);
      rem = rem - lim;
    end
  endtask

  task automatic scramble_cfg();
    cfg_page_bound_i            = 3'($urandom_range(0, 7));
    cfg_t_cs_max_i              = $urandom;
    cfg_t_read_write_recovery_i = $urandom;
  endtask

  // hold < 0 selects a random 0..3 cycle backpressure per sub-burst.
  task automatic run_req(input logic [31:0] addr, input int unsigned size, input bit rwn,
                         input logic [2:0] pb, input logic [31:0] cs_max,
                         input logic [31:0] rec, input int hold);
    int h;
    int j;
    int target;
    bit found;
    build_expected(addr, size, pb, cs_max);
    $display("req addr=0x%08h size=%0d rwn=%0d pb=%0d cs_max=%0d rec=%0d -> %0d sub-bursts",
             addr, size, rwn, pb, cs_max, rec, exp_q.size());
    chk("idle_ready", req_ready_o, 1);
    req_addr_i                  = addr;
    req_size_i                  = 16'(size);
    req_rwn_i                   = rwn;
    cfg_page_bound_i            = pb;
    cfg_t_cs_max_i              = cs_max;
    cfg_t_read_write_recovery_i = rec;
    req_valid_i                 = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    scramble_cfg();
    if (size == 0) begin
      chk("zero_ready", req_ready_o, 1);
      chk("zero_valid", sub_valid_o, 0);
      chk("zero_busy", busy_o, 0);
      return;
    end
    chk("calc_valid", sub_valid_o, 0);
    chk("calc_busy", busy_o, 1);
    chk("calc_ready", req_ready_o, 0);
    @(negedge clk);
    foreach (exp_q[k]) begin
      chk("sub_valid", sub_valid_o, 1);
      chk("sub_addr", sub_addr_o, exp_q[k].addr);
      chk("sub_size", sub_size_o, exp_q[k].size);
      chk("sub_rwn", sub_rwn_o, rwn);
      chk("sub_last", sub_last_o, exp_q[k].last);
      h = (hold < 0) ? $urandom_range(0, 3) : hold;
      repeat (h) begin
        scramble_cfg();
        sub_done_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("hold_valid", sub_valid_o, 1);
        chk("hold_addr", sub_addr_o, exp_q[k].addr);
        chk("hold_size", sub_size_o, exp_q[k].size);
      end
      sub_done_i  = 1'b0;
      sub_ready_i = 1'b1;
      @(negedge clk);
      sub_ready_i = 1'b0;
      chk("valid_drop", sub_valid_o, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sub_done_i = 1'b1;
      @(negedge clk);
      sub_done_i = 1'b0;
      target = exp_q[k].last ? int'(rec) + 1 : int'(rec) + 2;
      j = 1;
      found = 1'b0;
      while (!found && j <= target + 8) begin
        if (exp_q[k].last ? req_ready_o : sub_valid_o) begin
          found = 1'b1;
        end else begin
          sub_done_i = 1'($urandom_range(0, 1));
          @(negedge clk);
          j++;
        end
      end
      sub_done_i = 1'b0;
      if (exp_q[k].last) chk("ready_latency", j, target);
      else               chk("issue_latency", j, target);
    end
    chk("end_busy", busy_o, 0);
  endtask

  task automatic reset_test();
    $display("reset during WAIT_DONE");
    req_addr_i                  = 32'h70;
    req_size_i                  = 16'd16;
    req_rwn_i                   = 1'b1;
    cfg_page_bound_i            = 3'd0;
    cfg_t_cs_max_i              = 32'd0;
    cfg_t_read_write_recovery_i = 32'd0;
    req_valid_i                 = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    sub_ready_i = 1'b1;
    @(negedge clk);
    sub_ready_i = 1'b0;
    chk("wd_busy", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", sub_valid_o, 0);
    chk("rst_addr", sub_addr_o, 0);
    chk("rst_size", sub_size_o, 0);
    chk("rst_rwn", sub_rwn_o, 0);
    chk("rst_last", sub_last_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i      = 1'b0;
    sub_done_i = 1'b1;
    @(negedge clk);
    sub_done_i = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_valid", sub_valid_o, 0);
    chk("post_rst_ready", req_ready_o, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cs;
    int unsigned sz;
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready_o, 0);
    chk("reset_valid", sub_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_addr", sub_addr_o, 0);
    chk("reset_size", sub_size_o, 0);
    chk("reset_last", sub_last_o, 0);
    chk("reset_rwn", sub_rwn_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("release_ready", req_ready_o, 1);

    run_req(32'h70, 64, 1'b0, 3'd0, 32'd0, 32'd0, -1);
    run_req(32'h0, 150, 1'b1, 3'd7, 32'd32, 32'd1, -1);
    run_req(32'h70, 64, 1'b0, 3'd0, 32'd0, 32'd5, 0);
    run_req(32'h70, 64, 1'b1, 3'd0, 32'd0, 32'd2, 10);
    run_req(32'h1234, 0, 1'b0, 3'd0, 32'd0, 32'd3, 0);
    run_req(32'hFFFF_FFF0, 32, 1'b0, 3'd7, 32'd8, 32'd0, -1);
    run_req(32'h0, 65535, 1'b1, 3'd7, 32'd40000, 32'd0, -1);
    run_req(32'h3F8, 40, 1'b0, 3'd3, 32'd0, 32'd1, -1);
    reset_test();
    run_req(32'h70, 64, 1'b0, 3'd0, 32'd0, 32'd0, -1);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 2))
        0:       cs = 32'd0;
        1:       cs = 32'($urandom_range(8, 300));
        default: cs = 32'h8000_0000 | $urandom;
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700);
      run_req($urandom, sz, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              cs, 32'($urandom_range(0, 4)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
